// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter.
//   mem_state_e  : arbiter FSM states (IDLE, ACCESS, RESP)
//   REQ_IF/REQ_DM: requester IDs used for the winner and the response owner
//   MEM_RW_*     : encoding of the RAM rw line
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam logic MEM_RW_WRITE = 1'b1;
    localparam logic MEM_RW_READ  = 1'b0;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision between fetch and data requesters with fetch starvation guard.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_if_req         : fetch request
//   i_dm_req         : data request
//   i_grant_strobe   : high in every arbitration slot (arbiter idle)
//   o_winner         : winning requester ID (REQ_IF / REQ_DM), valid when any req is high
module mem_arb_pick
    import mem_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_if_req,
    input  logic i_dm_req,
    input  logic i_grant_strobe,
    output logic o_winner
);

    localparam int unsigned StarveW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
    localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_STARVE);

    logic [StarveW-1:0] r_starve;
    logic               w_force_if;

    assign w_force_if = (r_starve == StarveMax);

    // Data wins a contested slot unless fetch has lost MAX_STARVE times in a row.
    assign o_winner = (i_if_req && (!i_dm_req || w_force_if)) ? REQ_IF : REQ_DM;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (i_grant_strobe) begin
            if (!i_if_req || (o_winner == REQ_IF)) begin
                r_starve <= '0;
            end else if (!w_force_if) begin
                // Fetch is requesting but data won: count the loss, saturating.
                r_starve <= r_starve + StarveW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data RAM between instruction fetch and load/store.
// One request is accepted at a time; the RAM is driven for RAM_LAT cycles, the
// registered read data is captured and returned with a one-cycle rvalid pulse.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_if_req/i_if_addr             : fetch request; o_if_ready accept pulse
//   o_if_rvalid/o_if_err           : fetch response pulse and out-of-range flag
//   i_dm_req/i_dm_we/i_dm_addr/i_dm_wdata : data request; o_dm_ready accept pulse
//   o_dm_rvalid/o_dm_err           : data completion pulse and out-of-range flag
//   o_rdata                        : read data, valid with either rvalid
//   o_mem_enable/o_mem_rw/o_mem_addr/o_mem_wdata/i_mem_rdata : RAM interface
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned RAM_LAT    = 2,
    parameter int unsigned MAX_STARVE = 3,
    parameter int unsigned ADDR_BITS  = 13
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic        o_if_rvalid,
    output logic        o_if_err,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic        o_dm_ready,
    output logic        o_dm_rvalid,
    output logic        o_dm_err,
    output logic [31:0] o_rdata,
    output logic        o_mem_enable,
    output logic        o_mem_rw,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned CntW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(RAM_LAT - 1);

    mem_state_e    r_state;
    logic [CntW-1:0] r_cnt;
    logic          r_owner;
    logic          r_if_rvalid;
    logic          r_if_err;
    logic          r_dm_rvalid;
    logic          r_dm_err;
    logic [31:0]   r_rdata;
    logic          r_mem_enable;
    logic          r_mem_rw;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;

    logic          w_idle;
    logic          w_any_req;
    logic          w_winner;
    logic [31:0]   w_win_addr;
    logic          w_win_we;
    logic [31:0]   w_win_wdata;
    logic          w_out_of_range;

    assign w_idle    = (r_state == IDLE);
    assign w_any_req = i_if_req | i_dm_req;

    mem_arb_pick #(
        .MAX_STARVE(MAX_STARVE)
    ) u_pick (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_if_req      (i_if_req),
        .i_dm_req      (i_dm_req),
        .i_grant_strobe(w_idle),
        .o_winner      (w_winner)
    );

    assign w_win_addr     = (w_winner == REQ_DM) ? i_dm_addr : i_if_addr;
    assign w_win_we       = (w_winner == REQ_DM) ? i_dm_we : MEM_RW_READ;
    assign w_win_wdata    = (w_winner == REQ_DM) ? i_dm_wdata : 32'h0;
    assign w_out_of_range = ((w_win_addr >> ADDR_BITS) != 32'h0);

    // Accept is decided in the idle cycle itself; reset forces it low so every
    // output reads 0 while reset is held.
    assign o_if_ready = i_rst_n & w_idle & i_if_req & (w_winner == REQ_IF);
    assign o_dm_ready = i_rst_n & w_idle & i_dm_req & (w_winner == REQ_DM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_owner      <= REQ_IF;
            r_if_rvalid  <= 1'b0;
            r_if_err     <= 1'b0;
            r_dm_rvalid  <= 1'b0;
            r_dm_err     <= 1'b0;
            r_rdata      <= '0;
            r_mem_enable <= 1'b0;
            r_mem_rw     <= MEM_RW_READ;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_dm_err    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        if (w_out_of_range) begin
                            // Bad address: respond next cycle, RAM never enabled.
                            r_state     <= RESP;
                            r_rdata     <= '0;
                            r_if_rvalid <= (w_winner == REQ_IF);
                            r_if_err    <= (w_winner == REQ_IF);
                            r_dm_rvalid <= (w_winner == REQ_DM);
                            r_dm_err    <= (w_winner == REQ_DM);
                        end else begin
                            r_state      <= ACCESS;
                            r_cnt        <= CntLoad;
                            r_mem_enable <= 1'b1;
                            r_mem_rw     <= w_win_we;
                            r_mem_addr   <= w_win_addr;
                            r_mem_wdata  <= w_win_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state      <= RESP;
                        r_rdata      <= (r_mem_rw == MEM_RW_WRITE) ? 32'h0 : i_mem_rdata;
                        r_if_rvalid  <= (r_owner == REQ_IF);
                        r_dm_rvalid  <= (r_owner == REQ_DM);
                        r_mem_enable <= 1'b0;
                        r_mem_rw     <= MEM_RW_READ;
                        r_mem_addr   <= '0;
                        r_mem_wdata  <= '0;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_if_rvalid  = r_if_rvalid;
    assign o_if_err     = r_if_err;
    assign o_dm_rvalid  = r_dm_rvalid;
    assign o_dm_err     = r_dm_err;
    assign o_rdata      = r_rdata;
    assign o_mem_enable = r_mem_enable;
    assign o_mem_rw     = r_mem_rw;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single transactions with
// cycle-by-cycle expectations, plus starvation and mid-access reset sequences.
module tb_mem_port_arbiter;

    localparam int unsigned RAM_LAT    = 2;
    localparam int unsigned MAX_STARVE = 3;
    localparam int unsigned ADDR_BITS  = 13;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic        dm_rvalid;
    logic        dm_err;
    logic [31:0] rdata;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .RAM_LAT   (RAM_LAT),
        .MAX_STARVE(MAX_STARVE),
        .ADDR_BITS (ADDR_BITS)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_ready  (if_ready),
        .o_if_rvalid (if_rvalid),
        .o_if_err    (if_err),
        .i_dm_req    (dm_req),
        .i_dm_we     (dm_we),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .o_dm_ready  (dm_ready),
        .o_dm_rvalid (dm_rvalid),
        .o_dm_err    (dm_err),
        .o_rdata     (rdata),
        .o_mem_enable(mem_enable),
        .o_mem_rw    (mem_rw),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: samples on the falling edge, registered read data.
    logic [31:0] ram [int unsigned];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h404) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (mem_enable) begin
            if (mem_rw) ram[mem_addr] = mem_wdata;
            else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_word(mem_addr);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({if_ready, if_rvalid, if_err, dm_ready, dm_rvalid, dm_err, rdata,
                     mem_enable, mem_rw, mem_addr, mem_wdata});
    endfunction

    task automatic drop_reqs();
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
    endtask

    typedef struct packed {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [0:11];

    // One transaction from an idle arbiter; checks accept, bus and response timing.
    task automatic do_txn(input vec_t v, input string tag);
        int   waited;
        logic got;
        int   r_cyc;
        waited = 0;
        got    = 1'b0;
        @(posedge clk); #1;
        if (v.is_dm) begin
            dm_req   = 1'b1;
            dm_we    = v.we;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        while (!got && waited < 10) begin
            @(negedge clk);
            if (v.is_dm ? dm_ready : if_ready) got = 1'b1;
            else waited++;
        end
        check({tag, " accept"}, 128'({waited[7:0], if_ready, dm_ready}),
              128'({8'd0, !v.is_dm, v.is_dm}));
        if (!got) begin
            drop_reqs();
            return;
        end
        r_cyc = v.exp_err ? 1 : int'(RAM_LAT) + 1;
        for (int k = 1; k <= int'(RAM_LAT) + 1; k++) begin
            logic       en_exp;
            logic [5:0] exp_ctl;
            @(posedge clk); #1;
            if (k == 1) drop_reqs();
            @(negedge clk);
            en_exp  = !v.exp_err && (k <= int'(RAM_LAT));
            exp_ctl = '0;
            if (k == r_cyc) begin
                exp_ctl = v.is_dm ? {4'b0000, 1'b1, v.exp_err} : {2'b00, 1'b1, v.exp_err, 2'b00};
            end
            check($sformatf("%s c%0d ctl", tag, k),
                  128'({mem_enable, if_ready, dm_ready, if_rvalid, if_err, dm_rvalid, dm_err}),
                  128'({en_exp, exp_ctl}));
            if (en_exp) begin
                check($sformatf("%s c%0d bus", tag, k), 128'({mem_rw, mem_addr, mem_wdata}),
                      128'({v.is_dm & v.we, v.addr, (v.is_dm & v.we) ? v.wdata : 32'h0}));
            end else begin
                check($sformatf("%s c%0d bus idle", tag, k), 128'({mem_addr, mem_wdata}),
                      128'(0));
            end
            if (k == r_cyc) check($sformatf("%s rdata", tag), 128'(rdata), 128'(v.exp_rdata));
        end
    endtask

    // Both requesters held; exp_seq bit i is 1 when grant i should go to data.
    task automatic run_grants(input int n, input logic [7:0] exp_seq, input string tag);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        @(posedge clk); #1;
        if_req   = 1'b1;
        if_addr  = 32'h10;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h20;
        dm_wdata = '0;
        while (seen < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            check($sformatf("%s excl c%0d", tag, cyc),
                  128'({if_ready & dm_ready, if_rvalid & dm_rvalid, if_ready & if_rvalid,
                        dm_ready & dm_rvalid}), 128'(0));
            if (if_ready || dm_ready) begin
                check($sformatf("%s grant %0d", tag, seen), 128'(dm_ready), 128'(exp_seq[seen]));
                seen++;
            end
        end
        check({tag, " grants seen"}, 128'(seen), 128'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            is_dm we    addr           wdata          err   rdata
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0404, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_1C00, 32'h1234_5678, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_1C00, 32'h0,         1'b0, 32'h1234_5678};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_8000, 32'h0,         1'b1, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_1C00, 32'h0,         1'b0, 32'h1234_5678};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_1FFF, 32'hA5A5_5A5A, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_1FFF, 32'h0,         1'b0, 32'hA5A5_5A5A};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hC0DE_0000};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0ABC, 32'h0,         1'b0, 32'hC0DE_0ABC};

        rst_n = 1'b1;
        drop_reqs();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset values", all_outs(), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", all_outs(), 128'(0));

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Starvation: dm, dm, dm, if, dm, dm, dm, if.
        run_grants(8, 8'b0111_0111, "starve");
        @(posedge clk); #1;
        drop_reqs();
        repeat (6) @(posedge clk);

        // Build the starvation count to MAX_STARVE, then reset mid-access.
        run_grants(3, 8'b0000_0111, "prerst");
        @(posedge clk); #1;
        drop_reqs();
        @(posedge clk); #1;
        check("mid access enable", 128'(mem_enable), 128'(1));
        rst_n = 1'b0;
        #1;
        check("async reset clear", all_outs(), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post reset quiet %0d", i), all_outs(), 128'(0));
        end
        // Count was cleared: a contested slot goes to data, not fetch.
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = 32'h10;
        dm_req  = 1'b1;
        dm_addr = 32'h20;
        @(negedge clk);
        check("post reset grant", 128'({if_ready, dm_ready}), 128'(2'b01));
        @(posedge clk); #1;
        drop_reqs();
        repeat (5) @(posedge clk);
        do_txn(vecs[0], "post reset fetch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported data RAM between the instruction-fetch path and the load/store path of the core. Accepts one request at a time from either requester and drives the RAM's enable, rw, address and write-data lines for a fixed access window. Captures the RAM's registered read data and returns it to the winning requester with a one-cycle valid pulse. Sits between the core's fetch/LSU stages and the 8-chip RAM.

## Interface
- RAM_LAT, 2: cycles mem_enable is held per access; must be ≥1
- MAX_STARVE, 3: consecutive fetch losses before fetch is forced to win
- ADDR_BITS, 13: implemented word-address bits; bits above must be zero
---
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  32  fetch word address
- if_ready  out  1  one-cycle accept pulse for fetch
- if_rvalid  out  1  one-cycle response pulse for fetch
- if_err  out  1  valid with if_rvalid; address out of range
- dm_req  in  1  data request; held with dm_we, dm_addr, dm_wdata until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  32  data word address
- dm_wdata  in  32  store data
- dm_ready  out  1  one-cycle accept pulse for data
- dm_rvalid  out  1  one-cycle completion pulse for data; reads and writes
- dm_err  out  1  valid with dm_rvalid
- rdata  out  32  read data; valid with either rvalid
- mem_enable  out  1  RAM enable
- mem_rw  out  1  1 = write, 0 = read
- mem_addr  out  32  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner, latch its addr/we/wdata, assert its ready for this cycle.
  - Address in range: go to ACCESS with the counter loaded to RAM_LAT-1.
  - Out of range (addr[31:ADDR_BITS] ≠ 0): go to RESP with err=1; the RAM is not touched.
- Arbitration when both requesters are active:
  - dm wins, unless the starvation count equals MAX_STARVE, in which case if wins.
  - Starvation count increments each time if loses while if_req is high.
  - It clears when if wins or if_req is low in IDLE, and saturates at MAX_STARVE.
- Single requester: that requester wins regardless of the starvation count.
- ACCESS:
  - mem_enable=1; mem_rw, mem_addr and mem_wdata come from the latched values.
  - Fetch always drives mem_rw=0.
  - Counter decrements each cycle; at 0, register mem_rdata into rdata and go to RESP.
- RESP:
  - Pulse the winner's rvalid and err for one cycle; rdata holds the captured value.
  - rdata is 0 for writes and errors.
  - Go to IDLE.
- mem_addr and mem_wdata return to 0 whenever mem_enable=0.
- Protocol rules:
  - Requesters must not change their request fields while req=1 and ready=0.
  - Dropping req before ready withdraws the request legally.
  - req values in ACCESS or RESP are ignored; ready stays 0.

## Timing
- Reset values: every output is 0, the state is IDLE, and the starvation count is 0.
- Reset asserted mid-access: mem_enable drops at once and the in-flight access is abandoned with no rvalid.
- Accept at cycle T. mem_enable is high for cycles T+1 … T+RAM_LAT, and rvalid is high at cycle T+RAM_LAT+1.
- Error path: rvalid at T+1, with mem_enable never raised.
- Next accept is possible at T+RAM_LAT+2, so peak throughput is one access per RAM_LAT+2 cycles.
- Outputs are driven from rising-edge flops, so they are stable before the RAM's falling-edge sample.
- mem_rdata is sampled on the rising edge that ends the last ACCESS cycle.
- Both rvalid signals are never high in the same cycle; ready and rvalid for the same port are never high in the same cycle.

## Structure
- Shared package mem_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - requester ID constants REQ_IF=0 and REQ_DM=1;
  - MEM_RW_WRITE=1 and MEM_RW_READ=0.
- Sub-module mem_arb_pick:
  - Contains the starvation counter and the priority decision.
  - Inputs: clk, reset, if_req, dm_req, grant_strobe.
  - Outputs: the winner ID.
- The top-level module holds the FSM, the access counter, the latches and the response registers.

## Test plan
- Fetch only, if_addr=0x404, RAM word holding 0xDEADBEEF, RAM_LAT=2: if_ready at T, mem_enable high T+1..T+2 with mem_addr=0x404 and mem_rw=0, then if_rvalid at T+3 with rdata=0xDEADBEEF and if_err=0.
- Data write followed by data read at 0x1C00, dm_wdata=0x12345678: the write produces dm_rvalid with rdata=0; the read returns 0x12345678; mem_rw=1 only during the write's ACCESS cycles.
- Both requests held continuously, MAX_STARVE=3: grant sequence is dm, dm, dm, if, dm, dm, dm, if.
- dm_addr=0x0000_2000 (out of range): dm_ready at T, dm_rvalid and dm_err at T+1, mem_enable stays 0 throughout.
- reset driven low during the second ACCESS cycle: all outputs go to 0 immediately with no rvalid. After release, a new if_req is accepted from IDLE with the starvation count at 0.
